muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the main ALU and is sequenced by the core control FSM. The FSM pulses `start` with the decoded operation and both register operands, then stalls in a wait state until `done`. Internally a shift-add multiplier and a restoring divider share one 64-bit accumulator and are run by a small state machine. Signed operations are handled by magnitude conversion before the run and sign correction after it.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_sign.sv | 62 ++++++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Opcode and state encodings used by the unit and the decoder.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling around the unsigned core: operand magnitudes
// before the run, sign correction and word select after it.
module muldiv_sign
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_t            op_i,
  input  logic [XLEN-1:0]       src1_i,
  input  logic [XLEN-1:0]       src2_i,
  output logic                  neg1_o,
  output logic                  neg2_o,
  output logic [XLEN-1:0]       mag1_o,
  output logic [XLEN-1:0]       mag2_o,
  input  muldiv_op_t            fop_i,
  input  logic                  fneg1_i,
  input  logic                  fneg2_i,
  input  logic [2*XLEN-1:0]     acc_i,
  output logic [XLEN-1:0]       word_o
);

  logic sgn1, sgn2;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quo, rem;

  // MUL low word is sign-agnostic, so it runs unsigned
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    unique case (op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      OP_MULHSU: sgn1 = 1'b1;
      default: ;
    endcase
  end

  assign neg1_o = sgn1 & src1_i[XLEN-1];
  assign neg2_o = sgn2 & src2_i[XLEN-1];
  assign mag1_o = neg1_o ? -src1_i : src1_i;
  assign mag2_o = neg2_o ? -src2_i : src2_i;

  assign prod = (fneg1_i ^ fneg2_i) ? -acc_i : acc_i;
  assign quo  = (fneg1_i ^ fneg2_i) ? -acc_i[XLEN-1:0]
                                    : acc_i[XLEN-1:0];
  assign rem  = fneg1_i ? -acc_i[2*XLEN-1:XLEN]
                        : acc_i[2*XLEN-1:XLEN];

  always_comb begin
    word_o = '0;
    unique case (fop_i)
      OP_MUL:                       word_o = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: word_o = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              word_o = quo;
      OP_REM, OP_REMU:              word_o = rem;
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and restoring divide
// sharing one accumulator, 32 iterations plus a fix-up cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q;
  muldiv_op_t        op_q;
  logic              neg1_q, neg2_q;
  logic [XLEN-1:0]   opnd_q, result_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q;

  muldiv_op_t      op_in;
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2, fix_word;

  assign op_in = muldiv_op_t'(funct3);

  muldiv_sign #(.XLEN(XLEN)) u_sign (
    .op_i    (op_in),
    .src1_i  (src1),
    .src2_i  (src2),
    .neg1_o  (neg1),
    .neg2_o  (neg2),
    .mag1_o  (mag1),
    .mag2_o  (mag2),
    .fop_i   (op_q),
    .fneg1_i (neg1_q),
    .fneg2_i (neg2_q),
    .acc_i   (acc_q),
    .word_o  (fix_word)
  );

  logic            is_div, is_rem, div0, ovf;
  logic [XLEN-1:0] spec_res;

  assign is_div = funct3[2];
  assign is_rem = funct3[1];
  assign div0 = is_div & (src2 == '0);
  assign ovf  = is_div & ~funct3[0] & (src1 == SMIN) & (src2 == '1);

  always_comb begin
    spec_res = '0;
    if (div0) spec_res = is_rem ? src1 : '1;
    else if (!is_rem) spec_res = SMIN;
  end

  logic [XLEN:0]   madd;
  logic [XLEN+1:0] dsub;

  // Divide trial uses the 33-bit shifted remainder acc[63:31]
  always_comb begin
    madd = {1'b0, acc_q[2*XLEN-1:XLEN]}
         + (acc_q[0] ? {1'b0, opnd_q} : '0);
    dsub = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
    acc_d = {madd, acc_q[XLEN-1:1]};
    if (op_q[2]) begin
      if (dsub[XLEN+1])
        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
      else
        acc_d = {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            op_q   <= op_in;
            neg1_q <= neg1;
            neg2_q <= neg2;
            cnt_q  <= '0;
            acc_q  <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
            opnd_q <= is_div ? mag2 : mag1;
            if (div0 | ovf) begin
              result_q <= spec_res;
              state_q  <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_word;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q == RUN) | (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency,
// special divide cases, ignored starts, back-to-back, reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  int vecs = 0;
  int errs = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Launch one op and return done cycle, result, busy-window errors
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int busy_last,
                        output int dcyc, output logic [31:0] res,
                        output int busy_bad);
    dcyc = -1;
    res = 'x;
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    funct3 = op;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (busy !== (c <= busy_last)) busy_bad++;
      if (done === 1'b1) begin
        dcyc = c;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    funct3 = 3'b000;
    src1 = '0;
    src2 = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({busy, done, result} !== 34'd0) begin
      errs++;
      $display("FAIL reset: busy=%b done=%b result=%h, want 0/0/0",
               busy, done, result);
    end
    reset = 1'b1;
  endtask

  task automatic test_normal();
    logic [2:0]  ops[10];
    logic [31:0] as[10], bs[10], ex[10];
    int d, bb;
    logic [31:0] r;
    ops = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100,
            3'b110, 3'b101, 3'b111, 3'b101, 3'b111};
    as  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
            32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bs  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7,
            32'hFFFF_FFFE, 32'hFFFF_FFFE};
    ex  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
            32'd14, 32'd2, 32'd1, 32'd1};
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], 33, d, r, bb);
      vecs++;
      if (r !== ex[i] || d != 34 || bb != 0) begin
        errs++;
        $display("FAIL op%0d f3=%b: result=%h cyc=%0d busybad=%0d, want %h cyc=34 busybad=0",
                 i, ops[i], r, d, bb, ex[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops[4];
    logic [31:0] as[4], bs[4], ex[4];
    int d, bb;
    logic [31:0] r;
    ops = '{3'b100, 3'b110, 3'b100, 3'b110};
    as  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    ex  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 0, d, r, bb);
      vecs++;
      if (r !== ex[i] || d != 1 || bb != 0) begin
        errs++;
        $display("FAIL special%0d: result=%h cyc=%0d busybad=%0d, want %h cyc=1 busybad=0",
                 i, r, d, bb, ex[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int d = -1;
    logic [31:0] r = 'x;
    @(negedge clk);
    start = 1'b1;
    funct3 = 3'b000;
    src1 = 32'd7;
    src2 = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        d = c;
        r = result;
        break;
      end
      src1 = $urandom;
      src2 = $urandom;
      start = (c == 10);
      if (c == 10) funct3 = 3'b100;
    end
    start = 1'b0;
    vecs++;
    if (r !== 32'hFFFF_FFEB || d != 34) begin
      errs++;
      $display("FAIL ignore_start: result=%h cyc=%0d, want ffffffeb cyc=34",
               r, d);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic [31:0] r1 = 'x, r2 = 'x;
    @(negedge clk);
    start = 1'b1;
    funct3 = 3'b011;
    src1 = 32'hFFFF_FFFF;
    src2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          r1 = result;
          start = 1'b1;
          funct3 = 3'b000;
          src1 = 32'd3;
          src2 = 32'd4;
          @(posedge clk);
          #1 start = 1'b0;
        end else begin
          d2 = c;
          r2 = result;
          break;
        end
      end
    end
    vecs++;
    if (r1 !== 32'hFFFF_FFFE || d1 != 34) begin
      errs++;
      $display("FAIL b2b_first: result=%h cyc=%0d, want fffffffe cyc=34",
               r1, d1);
    end
    vecs++;
    if (r2 !== 32'd12 || d2 != 68) begin
      errs++;
      $display("FAIL b2b_second: result=%h cyc=%0d, want 0000000c cyc=68",
               r2, d2);
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    int d, bb;
    logic [31:0] r;
    @(negedge clk);
    start = 1'b1;
    funct3 = 3'b100;
    src1 = 32'd100;
    src2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++;
    if ({busy, done, result} !== 34'd0) begin
      errs++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h, want 0/0/0",
               busy, done, result);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    vecs++;
    if (seen != 0) begin
      errs++;
      $display("FAIL post_reset_quiet: active cycles=%0d, want 0", seen);
    end
    run_op(3'b000, 32'd3, 32'd4, 33, d, r, bb);
    vecs++;
    if (r !== 32'd12 || d != 34 || bb != 0) begin
      errs++;
      $display("FAIL after_reset_mul: result=%h cyc=%0d busybad=%0d, want 0000000c cyc=34 busybad=0",
               r, d, bb);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
